// File: rtl/restoring_divider_if.sv
// restoring_divider_if: start/done handshake and operand/result bus; optional RESTORING_DIVIDER_DZ_FLAG_EN adds o_div_by_zero
interface restoring_divider_if #(parameter int n = 8);
  logic         i_start;
  logic [n-1:0] i_dividend;
  logic [n-1:0] i_divisor;
  logic [n-1:0] o_quotient;
  logic [n-1:0] o_remainder;
  logic         o_done;
`ifdef RESTORING_DIVIDER_DZ_FLAG_EN
  logic         o_div_by_zero;
  modport master (output i_start, i_dividend, i_divisor, input o_quotient, o_remainder, o_done, o_div_by_zero);
  modport slave  (input i_start, i_dividend, i_divisor, output o_quotient, o_remainder, o_done, o_div_by_zero);
`else
  modport master (output i_start, i_dividend, i_divisor, input o_quotient, o_remainder, o_done);
  modport slave  (input i_start, i_dividend, i_divisor, output o_quotient, o_remainder, o_done);
`endif
endinterface

// File: rtl/restoring_divider.sv
// restoring_divider: sequential unsigned restoring divider, one quotient bit per two cycles; RESTORING_DIVIDER_DZ_FLAG_EN adds a divide-by-zero flag
module restoring_divider #(parameter int n = 8) (
  input logic               clk,
  input logic               rst_n,
  restoring_divider_if.slave bus
);
  localparam int CW = $clog2(n + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  logic [n:0]    r_a;
  logic [n-1:0]  r_q;
  logic [n-1:0]  r_m;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_state;
  logic [n-1:0]  r_quo;
  logic [n-1:0]  r_rem;
  logic          r_done;
  logic [n:0]    w_sh;
  logic [n:0]    w_a_fix;
  logic [n-1:0]  w_q_fix;
  // shift stage input and the restore/quotient-bit decision of the check stage
  always_comb begin
    w_sh    = {r_a[n-1:0], r_q[n-1]};
    w_a_fix = r_a[n] ? r_a + {1'b0, r_m} : r_a;
    w_q_fix = {r_q[n-1:1], ~r_a[n]};
  end
`ifdef RESTORING_DIVIDER_DZ_FLAG_EN
  logic r_dz;
  // flag reflects the divisor of the most recently completed division
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_dz <= 1'b0;
    else if ((r_state == S_IDLE || r_state == S_DONE) && bus.i_start) r_dz <= 1'b0;
    else if (r_state == S_CHECK && r_cnt == CW'(1)) r_dz <= (r_m == '0);
  assign bus.o_div_by_zero = r_dz;
`endif
  // control FSM and datapath: capture, shift-subtract, restore, publish
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_state <= S_IDLE;
      r_quo   <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          r_a     <= w_sh - {1'b0, r_m};
          r_q     <= {r_q[n-2:0], 1'b0};
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_a   <= w_a_fix;
          r_q   <= w_q_fix;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_quo   <= w_q_fix;
            r_rem   <= w_a_fix[n-1:0];
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else r_state <= S_SHIFT;
        end
        default:
          if (bus.i_start) begin
            r_a     <= '0;
            r_q     <= bus.i_dividend;
            r_m     <= bus.i_divisor;
            r_cnt   <= CW'(n);
            r_done  <= 1'b0;
            r_state <= S_SHIFT;
          end
      endcase
    end
  assign bus.o_quotient  = r_quo;
  assign bus.o_remainder = r_rem;
  assign bus.o_done      = r_done;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed vectors with a scoreboard queue checked by an independent done monitor
module tb_restoring_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic prev_done = 1'b0;
  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         acc;
  } exp_t;
  exp_t sb[$];
  restoring_divider_if #(.n(8)) bus();
  restoring_divider #(.n(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq, input logic [7:0] er, input logic edz);
    exp_t e;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_dividend = a;
    bus.i_divisor = b;
    e.q = eq;
    e.r = er;
    e.dz = edz;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask
  task automatic wait_done();
    int k = 0;
    while (!bus.o_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!bus.o_done) begin
      fails++;
      $display("FAIL done_timeout: done=0 after %0d cycles, expected 1", k);
    end
  endtask
  // monitor: every rising done is matched against the oldest outstanding expectation
  initial forever begin
    @(negedge clk);
    if (!rst_n) prev_done = 1'b0;
    else begin
      if (bus.o_done && !prev_done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", int'(bus.o_quotient), int'(e.q));
          chk("remainder", int'(bus.o_remainder), int'(e.r));
          chk("latency", cyc - e.acc, 16);
`ifdef RESTORING_DIVIDER_DZ_FLAG_EN
          chk("div_by_zero", int'(bus.o_div_by_zero), int'(e.dz));
`endif
        end
      end
      prev_done = bus.o_done;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_start = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor = '0;
    repeat (2) @(negedge clk);
    chk("reset_quotient", int'(bus.o_quotient), 0);
    chk("reset_remainder", int'(bus.o_remainder), 0);
    chk("reset_done", int'(bus.o_done), 0);
    rst_n = 1'b1;
    issue(8'd23, 8'd3, 8'd7, 8'd2, 1'b0);
    wait_done();
    repeat (5) @(negedge clk);
    chk("hold_quotient", int'(bus.o_quotient), 7);
    chk("hold_remainder", int'(bus.o_remainder), 2);
    chk("hold_done", int'(bus.o_done), 1);
    issue(8'd70, 8'd35, 8'd2, 8'd0, 1'b0);
    wait_done();
    issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    chk("done_drop", int'(bus.o_done), 0);
    chk("old_quotient_kept", int'(bus.o_quotient), 2);
    wait_done();
    issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    wait_done();
    issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    wait_done();
    issue(8'd0, 8'd13, 8'd0, 8'd0, 1'b0);
    wait_done();
    issue(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    wait_done();
    issue(8'h5A, 8'd0, 8'hFF, 8'h5A, 1'b1);
    wait_done();
    issue(8'd23, 8'd3, 8'd7, 8'd2, 1'b0);
`ifdef RESTORING_DIVIDER_DZ_FLAG_EN
    chk("dz_clear_on_start", int'(bus.o_div_by_zero), 0);
`endif
    wait_done();
    issue(8'd100, 8'd9, 8'd11, 8'd1, 1'b0);
    bus.i_dividend = 8'd3;
    bus.i_divisor = 8'd3;
    repeat (3) @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_dividend = 8'd250;
    bus.i_divisor = 8'd2;
    repeat (5) @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done();
    issue(8'd23, 8'd3, 8'd7, 8'd2, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_quotient", int'(bus.o_quotient), 0);
    chk("midreset_remainder", int'(bus.o_remainder), 0);
    chk("midreset_done", int'(bus.o_done), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'd23, 8'd3, 8'd7, 8'd2, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned integer divider using the restoring algorithm.
- Processes one quotient bit per two clock cycles.
- Start/done handshake; registered quotient and remainder.
- Standalone arithmetic unit for datapaths that tolerate multi-cycle latency.

Parameters:
- n, 8, operand width in bits; applies to dividend, divisor, quotient and remainder (n >= 2).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse requesting a division
- dividend  input  n  unsigned dividend, sampled on the accepting edge
- divisor  input  n  unsigned divisor, sampled on the accepting edge
- quotient  output  n  registered quotient
- remainder  output  n  registered remainder
- done  output  1  high while the last result is valid

Behaviour:
- Internal registers:
  - A: n+1 bits, signed partial remainder.
  - Q: n bits, dividend/quotient shift register.
  - M: n bits, divisor.
  - cnt: iteration counter, ceil(log2(n+1)) bits.
  - state: 2 bits.
- States: IDLE, SHIFT, CHECK, DONE.
- Reset (reset=0, asynchronous): state=IDLE, quotient=0, remainder=0, done=0, A=Q=M=cnt=0. Applies immediately, including mid-operation; any partial work is discarded.
- IDLE:
  - start=1 at a rising edge: A<=0, Q<=dividend, M<=divisor, cnt<=n, next state SHIFT.
  - start=0: stay in IDLE.
- SHIFT: {A,Q} <= {A,Q} shifted left by 1, then A <= shifted A - {0,M}, all in the same edge. Next state CHECK.
- CHECK:
  - A[n]=1 (negative): A <= A + {0,M} (restore), Q[0] <= 0.
  - A[n]=0: Q[0] <= 1.
  - cnt <= cnt-1.
  - cnt was 1 before this edge: quotient <= final Q, remainder <= final A[n-1:0], done <= 1, next state DONE.
  - Otherwise next state SHIFT.
- DONE:
  - quotient, remainder and done hold.
  - start=1: done <= 0, operands captured exactly as in IDLE, next state SHIFT.
- Latency: done rises exactly 2n rising edges after the edge that accepts start (16 cycles for n=8).
- quotient and remainder change only on the completing CHECK edge. Previous results stay visible during a new operation; done is low during that time.
- start asserted while in SHIFT or CHECK is ignored. Operand input changes after the accepting edge have no effect.
- Divisor 0 is not trapped: quotient = all ones, remainder = dividend. This is the natural result of the algorithm.
- Arithmetic is unsigned only. Required result: dividend = quotient*divisor + remainder, with remainder < divisor whenever divisor != 0.

Optional Feature:
- Macro: RESTORING_DIVIDER_DZ_FLAG_EN.
- Defined:
  - Adds output port div_by_zero (1 bit).
  - Registered; set on the completing CHECK edge when the captured M == 0, otherwise cleared on that edge.
  - Cleared by reset and when a new start is accepted.
  - Timing and all other outputs are unchanged.
- Undefined: port and logic absent; divide-by-zero gives the all-ones/dividend result with no flag.

Test Plan:
- Reset, then dividend=23 (0x17), divisor=3, 1-cycle start -> after 16 cycles done=1, quotient=7, remainder=2. Results hold while start=0.
- dividend=70, divisor=35 -> quotient=2, remainder=0. Then dividend=200, divisor=7 issued from DONE -> done drops the next cycle; 16 cycles later quotient=28, remainder=4.
- Edge values:
  - 255/1 -> 255 r0.
  - 5/9 -> 0 r5.
  - 0/13 -> 0 r0.
  - 255/255 -> 1 r0.
- Divisor 0, dividend 0x5A -> quotient=0xFF, remainder=0x5A. With macro defined, div_by_zero=1; it clears on the next nonzero-divisor division.
- Start pulses and operand changes mid-computation are ignored: result matches the originally captured operands and latency stays 16.
- reset=0 asserted mid-operation (e.g. cycle 8) -> outputs zero immediately and state IDLE. After release, a fresh start of 23/3 completes normally.
